main_decoder: RTL and testbench
===============================

MAIN_DECODER -- requirements
Module: MainDecoder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: `clk` input, 1 bit, rising-edge clock; `rst_n` input, 1 bit, asynchronous active-low reset.
REQ-002 `op` SHALL be an input, 2 bits, instr[27:26].
REQ-003 `funct` SHALL be an input, 6 bits, instr[25:20].
REQ-004 `instr74` SHALL be an input, 4 bits, instr[7:4].
REQ-005 The single-bit outputs SHALL be:
- `branch`: branch taken class.
- `mem_to_reg`: writeback data from memory.
- `mem_w`: memory write enable.
- `alu_src`: ALU operand B is an immediate.
- `reg_w3`: register write, port 3 (Rd/RdHi/link).
- `reg_w1`: register write, port 1 (base writeback / Rd of MUL / RdLo).
- `alu_op`: data-processing ALU decode enable.
- `post_idx`: post-indexed address.
- `mult`: multiply instruction.
REQ-006 The 2-bit outputs SHALL be `imm_src` (immediate format select) and `reg_src` (register-address select).
REQ-007 `ctrl_q` SHALL be an output, 13 bits, holding the registered copy of the control word (debug and pipeline tap).

Function
REQ-008 All control outputs except `ctrl_q` SHALL be purely combinational from `op`, `funct` and `instr74`, with no clock dependency, and SHALL settle within the same evaluation.
REQ-009 The control word order SHALL be {branch, mem_to_reg, mem_w, alu_src, imm_src[1:0], reg_w3, reg_w1, reg_src[1:0], alu_op, post_idx, mult}, MSB first.
REQ-010 Every signal not listed for a class below SHALL be 0.
REQ-011 Decode priority within op=00 SHALL be: BX, then multiply, then data-processing.
REQ-012 BX (op=00, funct=010010, instr74=0001): branch=1; all other outputs 0.
REQ-013 Multiply (op=00, funct[5]=0, instr74=1001, not BX): mult=1, reg_w1=1, reg_w3=funct[3] (1 for 64-bit long multiply), alu_op=0, alu_src=0.
REQ-014 Data-processing (op=00, otherwise): reg_w3=1, alu_op=1, alu_src=funct[5], imm_src=00.
REQ-015 Memory (op=01), with funct bits [5]=~I, [4]=P, [1]=W, [0]=L:
- imm_src=01.
- alu_src=~funct[5].
- mem_to_reg=L, reg_w3=L, mem_w=~L.
- reg_w1=(~P)|W.
- post_idx=~P.
- alu_op=0.
- `instr74` ignored.
REQ-016 Memory decode SHALL NOT depend on funct[3:2]; X/Z on those bits SHALL NOT propagate to any output.
REQ-017 Branch (op=10): branch=1, alu_src=1, imm_src=10, reg_w3=funct[4] (link), reg_src={funct[4],1}.
REQ-018 op=11 (undefined) SHALL drive all outputs 0.
REQ-019 `ctrl_q` SHALL capture the control word on every rising `clk`, giving a latency of one cycle.

Reset
REQ-020 Asserting `rst_n` low SHALL clear `ctrl_q` to 0 immediately, independent of `clk`.
REQ-021 Reset SHALL NOT affect the combinational outputs.
REQ-022 Sampling of `ctrl_q` SHALL resume at the first rising `clk` after `rst_n` deasserts.

Structure
REQ-023 A shared package SHALL hold:
- op-class constants: DP=00, MEM=01, BR=10.
- imm_src encodings: 00, 01, 10.
- the BX funct/instr74 pattern 010010/0001.
- the MUL instr74 pattern 1001.
- a 13-bit control-word packed struct.
REQ-024 The design SHALL have no sub-module: one combinational decode block plus one register.

Verification
REQ-025 DP register and DP immediate: op=00, funct=000000, instr74=0001 -> word 0_0_0_0_00_1_0_00_1_0_0; op=00, funct=100000, instr74=0000 -> 0_0_0_1_00_1_0_00_1_0_0.
REQ-026 Multiply: op=00, instr74=1001; funct=000000 -> 0_0_0_0_00_0_1_00_0_0_1; funct=001000 -> 0_0_0_0_00_1_1_00_0_0_1.
REQ-027 Memory with funct[3:2]=XX:
- STR funct=00XX00 -> 0_0_1_1_01_0_1_00_0_1_0.
- LDR funct=11XX11 -> 0_1_0_0_01_1_1_00_0_0_0.
- STR funct=01XX00, instr74=1001 -> 0_0_1_1_01_0_0_00_0_0_0.
REQ-028 Branch: op=10; funct=100000 -> 1_0_0_1_10_0_0_01_0_0_0; funct=110000 -> 1_0_0_1_10_1_0_11_0_0_0.
REQ-029 BX: op=00, funct=010010, instr74=0001 -> 1_0_0_0_00_0_0_00_0_0_0.
REQ-030 op=11 -> all-zero word.
REQ-031 Register timing: `ctrl_q` equals the previous-cycle word after one `clk`; `rst_n` low mid-cycle zeroes `ctrl_q` without a clock edge.

Source files
------------

// File: rtl/main_decoder_pkg.sv
// Shared constants and control-word layout for the main decoder.
// Field order of ctrl_t is the bit order of the exported control word.
package main_decoder_pkg;

  localparam int CTRL_W = 13;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;

  localparam logic [5:0] BX_FUNCT    = 6'b010010;
  localparam logic [3:0] BX_INSTR74  = 4'b0001;
  localparam logic [3:0] MUL_INSTR74 = 4'b1001;

  typedef struct packed {
    logic       branch;
    logic       mem_to_reg;
    logic       mem_w;
    logic       alu_src;
    logic [1:0] imm_src;
    logic       reg_w3;
    logic       reg_w1;
    logic [1:0] reg_src;
    logic       alu_op;
    logic       post_idx;
    logic       mult;
  } ctrl_t;

endpackage

// File: rtl/main_decoder.sv
// Main instruction decoder: combinational control word plus
// a registered copy for debug and pipeline tapping.
module main_decoder
  import main_decoder_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        op,
  input  logic [5:0]        funct,
  input  logic [3:0]        instr74,
  output logic              branch,
  output logic              mem_to_reg,
  output logic              mem_w,
  output logic              alu_src,
  output logic [1:0]        imm_src,
  output logic              reg_w3,
  output logic              reg_w1,
  output logic [1:0]        reg_src,
  output logic              alu_op,
  output logic              post_idx,
  output logic              mult,
  output logic [CTRL_W-1:0] ctrl_q
);

  ctrl_t ctrl;
  logic  is_bx;
  logic  is_mul;

  assign is_bx  = (funct == BX_FUNCT) && (instr74 == BX_INSTR74);
  assign is_mul = !funct[5] && (instr74 == MUL_INSTR74);

  // Memory path reads only funct[5,4,1,0] so unknown [3:2] stay contained
  always_comb begin
    ctrl = '0;
    unique case (op)
      OP_DP: begin
        unique case (1'b1)
          is_bx: begin
            ctrl.branch = 1'b1;
          end
          is_mul: begin
            ctrl.mult   = 1'b1;
            ctrl.reg_w1 = 1'b1;
            ctrl.reg_w3 = funct[3];
          end
          default: begin
            ctrl.reg_w3  = 1'b1;
            ctrl.alu_op  = 1'b1;
            ctrl.alu_src = funct[5];
            ctrl.imm_src = IMM_DP;
          end
        endcase
      end
      OP_MEM: begin
        ctrl.imm_src    = IMM_MEM;
        ctrl.alu_src    = ~funct[5];
        ctrl.mem_to_reg = funct[0];
        ctrl.reg_w3     = funct[0];
        ctrl.mem_w      = ~funct[0];
        ctrl.reg_w1     = ~funct[4] | funct[1];
        ctrl.post_idx   = ~funct[4];
      end
      OP_BR: begin
        ctrl.branch  = 1'b1;
        ctrl.alu_src = 1'b1;
        ctrl.imm_src = IMM_BR;
        ctrl.reg_w3  = funct[4];
        ctrl.reg_src = {funct[4], 1'b1};
      end
      default: begin
        ctrl = '0;
      end
    endcase
  end

  assign branch     = ctrl.branch;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign mem_w      = ctrl.mem_w;
  assign alu_src    = ctrl.alu_src;
  assign imm_src    = ctrl.imm_src;
  assign reg_w3     = ctrl.reg_w3;
  assign reg_w1     = ctrl.reg_w1;
  assign reg_src    = ctrl.reg_src;
  assign alu_op     = ctrl.alu_op;
  assign post_idx   = ctrl.post_idx;
  assign mult       = ctrl.mult;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= ctrl;
    end
  end

endmodule

// File: tb/tb_main_decoder.sv
// Directed plus random checks of the main decoder against a
// rule-level reference model.
module tb_main_decoder;

  logic        clk;
  logic        rst_n;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic [3:0]  instr74;
  logic        branch;
  logic        mem_to_reg;
  logic        mem_w;
  logic        alu_src;
  logic [1:0]  imm_src;
  logic        reg_w3;
  logic        reg_w1;
  logic [1:0]  reg_src;
  logic        alu_op;
  logic        post_idx;
  logic        mult;
  logic [12:0] ctrl_q;

  int checks   = 0;
  int failures = 0;

  main_decoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .funct      (funct),
    .instr74    (instr74),
    .branch     (branch),
    .mem_to_reg (mem_to_reg),
    .mem_w      (mem_w),
    .alu_src    (alu_src),
    .imm_src    (imm_src),
    .reg_w3     (reg_w3),
    .reg_w1     (reg_w1),
    .reg_src    (reg_src),
    .alu_op     (alu_op),
    .post_idx   (post_idx),
    .mult       (mult),
    .ctrl_q     (ctrl_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] word_of(
    logic b, logic m2r, logic mw, logic as, logic [1:0] is,
    logic w3, logic w1, logic [1:0] rs, logic ao, logic pi, logic mu);
    return {b, m2r, mw, as, is, w3, w1, rs, ao, pi, mu};
  endfunction

  // Reference decode written straight from the instruction-class rules
  function automatic logic [12:0] model(
    logic [1:0] o, logic [5:0] f, logic [3:0] i);
    logic p, w, l, ni;
    if (o == 2'b00) begin
      if (f == 6'b010010 && i == 4'b0001)
        return word_of(1,0,0,0,2'b00,0,0,2'b00,0,0,0);
      if (f[5] == 1'b0 && i == 4'b1001)
        return word_of(0,0,0,0,2'b00,f[3],1,2'b00,0,0,1);
      return word_of(0,0,0,f[5],2'b00,1,0,2'b00,1,0,0);
    end
    if (o == 2'b01) begin
      ni = f[5]; p = f[4]; w = f[1]; l = f[0];
      return word_of(0,l,!l,!ni,2'b01,l,(!p)|w,2'b00,0,!p,0);
    end
    if (o == 2'b10)
      return word_of(1,0,0,1,2'b10,f[4],0,{f[4],1'b1},0,0,0);
    return 13'd0;
  endfunction

  function automatic logic [12:0] comb_word();
    return {branch, mem_to_reg, mem_w, alu_src, imm_src,
            reg_w3, reg_w1, reg_src, alu_op, post_idx, mult};
  endfunction

  task automatic check(string tag, logic [12:0] obs, logic [12:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic apply(string tag, logic [1:0] o, logic [5:0] f,
                       logic [3:0] i, logic [12:0] exp);
    op = o; funct = f; instr74 = i;
    #1;
    check({tag, "_comb"}, comb_word(), exp);
    @(posedge clk);
    #1;
    check({tag, "_q"}, ctrl_q, exp);
  endtask

  logic [1:0]  ro;
  logic [5:0]  rf;
  logic [3:0]  ri;
  logic [12:0] prev;

  initial begin
    rst_n = 1'b0;
    op = 2'b10; funct = 6'b110000; instr74 = 4'b0000;
    #2;
    check("reset_q", ctrl_q, 13'd0);
    check("reset_comb", comb_word(), 13'b1_0_0_1_10_1_0_11_0_0_0);
    @(posedge clk);
    #1;
    check("reset_hold_q", ctrl_q, 13'd0);
    #2 rst_n = 1'b1;

    apply("dp_reg", 2'b00, 6'b000000, 4'b0001, 13'b0_0_0_0_00_1_0_00_1_0_0);
    apply("dp_imm", 2'b00, 6'b100000, 4'b0000, 13'b0_0_0_1_00_1_0_00_1_0_0);
    apply("mul", 2'b00, 6'b000000, 4'b1001, 13'b0_0_0_0_00_0_1_00_0_0_1);
    apply("mull", 2'b00, 6'b001000, 4'b1001, 13'b0_0_0_0_00_1_1_00_0_0_1);
    apply("str_x", 2'b01, 6'b00xx00, 4'b0000, 13'b0_0_1_1_01_0_1_00_0_1_0);
    apply("ldr_x", 2'b01, 6'b11xx11, 4'b0000, 13'b0_1_0_0_01_1_1_00_0_0_0);
    apply("str_pre", 2'b01, 6'b01xx00, 4'b1001, 13'b0_0_1_1_01_0_0_00_0_0_0);
    apply("b", 2'b10, 6'b100000, 4'b0000, 13'b1_0_0_1_10_0_0_01_0_0_0);
    apply("bl", 2'b10, 6'b110000, 4'b0000, 13'b1_0_0_1_10_1_0_11_0_0_0);
    apply("bx", 2'b00, 6'b010010, 4'b0001, 13'b1_0_0_0_00_0_0_00_0_0_0);
    apply("undef", 2'b11, 6'b111111, 4'b1111, 13'd0);
    apply("dp_imm_mulpat", 2'b00, 6'b100000, 4'b1001, 13'b0_0_0_1_00_1_0_00_1_0_0);

    // Asynchronous clear mid-cycle, combinational path unaffected
    apply("pre_rst", 2'b10, 6'b110000, 4'b0000, 13'b1_0_0_1_10_1_0_11_0_0_0);
    #2 rst_n = 1'b0;
    #1;
    check("async_clr_q", ctrl_q, 13'd0);
    check("async_clr_comb", comb_word(), 13'b1_0_0_1_10_1_0_11_0_0_0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("post_rst_q", ctrl_q, 13'd0);
    @(posedge clk);
    #1;
    check("resume_q", ctrl_q, 13'b1_0_0_1_10_1_0_11_0_0_0);

    prev = model(op, funct, instr74);
    for (int n = 0; n < 300; n++) begin
      ro = 2'($urandom);
      rf = 6'($urandom);
      ri = 4'($urandom);
      case ($urandom_range(0, 3))
        0: begin ro = 2'b00; rf = 6'b010010; ri = 4'b0001; end
        1: ri = 4'b1001;
        default: ;
      endcase
      op = ro; funct = rf; instr74 = ri;
      #1;
      check("rand_comb", comb_word(), model(ro, rf, ri));
      check("rand_lag_q", ctrl_q, prev);
      @(posedge clk);
      #1;
      prev = model(ro, rf, ri);
      check("rand_q", ctrl_q, prev);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
